// File: rtl/sfo_harmonic_correlator_multi.sv
// Parallel SFO hypothesis correlator: sums harmonic-bin and off-harmonic power per hypothesis
// over one FFT frame, then reports each hypothesis and the best one without a divider.
module sfo_harmonic_correlator_multi #(
    parameter int FFT_LEN_LOG2           = 9,
    parameter int POWER_WIDTH            = 16,
    parameter int NUM_HYP                = 4,
    parameter int SFO_INT_WIDTH          = 9,
    parameter int SFO_FRAC_WIDTH         = 16,
    parameter int MAX_NUM_HARMONICS_LOG2 = 5,
    parameter int SKIRT_WIDTH            = 2,
    parameter int THRESH_FRAC_BITS       = 8,
    localparam int HYP_W = (NUM_HYP > 1) ? $clog2(NUM_HYP) : 1,
    localparam int ACC_W = POWER_WIDTH + FFT_LEN_LOG2
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_start,
    input  logic [NUM_HYP*SFO_INT_WIDTH-1:0]    i_sfo_int_part,
    input  logic [NUM_HYP*SFO_FRAC_WIDTH-1:0]   i_sfo_frac_part,
    input  logic [MAX_NUM_HARMONICS_LOG2-1:0]   i_num_harmonics,
    input  logic [POWER_WIDTH-1:0]              i_corr_threshold,
    input  logic                                i_bin_valid,
    input  logic [POWER_WIDTH-1:0]              i_bin_mag,
    input  logic                                i_bin_last,
    output logic                                o_busy,
    output logic                                o_hyp_valid,
    output logic [HYP_W-1:0]                    o_hyp_index,
    output logic [ACC_W-1:0]                    o_hyp_num,
    output logic [ACC_W-1:0]                    o_hyp_den,
    output logic                                o_hyp_meets,
    output logic                                o_best_valid,
    output logic                                o_best_found,
    output logic [HYP_W-1:0]                    o_best_index,
    output logic [ACC_W-1:0]                    o_best_num,
    output logic [ACC_W-1:0]                    o_best_den
);
    localparam int POS_W  = FFT_LEN_LOG2 + 1;
    localparam int SK_W   = (SKIRT_WIDTH > 0) ? $clog2(SKIRT_WIDTH + 1) : 1;
    localparam int MH_W   = MAX_NUM_HARMONICS_LOG2;
    localparam int CMP_W  = POWER_WIDTH + ACC_W + THRESH_FRAC_BITS;
    localparam int PROD_W = 2 * ACC_W;
    localparam logic [SK_W-1:0]  SK_MAX    = SK_W'(SKIRT_WIDTH);
    localparam logic [POS_W-1:0] SKIRT_EXT = POS_W'(SKIRT_WIDTH);
    localparam logic [SFO_FRAC_WIDTH-1:0] FRAC_HALF = {1'b1, {(SFO_FRAC_WIDTH-1){1'b0}}};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]                r_state;
    logic [FFT_LEN_LOG2-1:0]   r_bin_idx;
    logic [MH_W-1:0]           r_nharm;
    logic [POWER_WIDTH-1:0]    r_thresh;
    logic [HYP_W-1:0]          r_cnt;
    logic [NUM_HYP-1:0]        r_hvalid;
    logic [SFO_INT_WIDTH-1:0]  r_int   [NUM_HYP];
    logic [SFO_FRAC_WIDTH-1:0] r_fracp [NUM_HYP];
    logic [SFO_FRAC_WIDTH-1:0] r_frac  [NUM_HYP];
    logic [POS_W-1:0]          r_pos   [NUM_HYP];
    logic [MH_W-1:0]           r_hc    [NUM_HYP];
    logic [SK_W-1:0]           r_sk    [NUM_HYP];
    logic [ACC_W-1:0]          r_num   [NUM_HYP];
    logic [ACC_W-1:0]          r_den   [NUM_HYP];

    logic                      r_best_found, r_out_found, r_hold_meets;
    logic [HYP_W-1:0]          r_best_idx, r_out_idx, r_hold_idx;
    logic [ACC_W-1:0]          r_best_num, r_best_den, r_out_num, r_out_den;
    logic [ACC_W-1:0]          r_hold_num, r_hold_den;

    logic [SFO_INT_WIDTH-1:0]  w_int_in  [NUM_HYP];
    logic [SFO_FRAC_WIDTH-1:0] w_frac_in [NUM_HYP];
    logic [SFO_FRAC_WIDTH:0]   w_frac_sum [NUM_HYP];
    logic [NUM_HYP-1:0]        w_active, w_harm, w_den_hit;
    logic [POS_W-1:0]          w_idx_ext;
    logic                      w_accept, w_frame_end, w_report;

    assign w_idx_ext   = {1'b0, r_bin_idx};
    assign w_accept    = (r_state == ST_ACCUM) && i_bin_valid;
    assign w_frame_end = w_accept && (i_bin_last || (r_bin_idx == '1));
    assign w_report    = (r_state == ST_REPORT);

    always_comb begin
        for (int k = 0; k < NUM_HYP; k++) begin
            w_int_in[k]   = i_sfo_int_part[k*SFO_INT_WIDTH +: SFO_INT_WIDTH];
            w_frac_in[k]  = i_sfo_frac_part[k*SFO_FRAC_WIDTH +: SFO_FRAC_WIDTH];
            w_frac_sum[k] = {1'b0, r_frac[k]} + {1'b0, r_fracp[k]};
            w_active[k]   = r_hvalid[k] && (r_hc[k] < r_nharm);
            w_harm[k]     = w_active[k] && (w_idx_ext == r_pos[k]);
            // Off-harmonic bins count only once the skirt after the last harmonic has passed.
            w_den_hit[k]  = w_active[k] && !w_harm[k] && (r_bin_idx != '0) &&
                            ((w_idx_ext + SKIRT_EXT) < r_pos[k]) && (r_sk[k] >= SK_MAX);
        end
    end

    logic [ACC_W-1:0]  w_cur_num, w_cur_den, w_cur_den1, w_best_den1;
    logic [CMP_W-1:0]  w_lhs, w_rhs;
    logic [PROD_W-1:0] w_prod_new, w_prod_best;
    logic              w_meets, w_take;

    assign w_cur_num   = r_num[r_cnt];
    assign w_cur_den   = r_den[r_cnt];
    assign w_cur_den1  = (w_cur_den == '0) ? ACC_W'(1) : w_cur_den;
    assign w_best_den1 = (r_best_den == '0) ? ACC_W'(1) : r_best_den;
    assign w_lhs       = CMP_W'(w_cur_num) << THRESH_FRAC_BITS;
    assign w_rhs       = CMP_W'(r_thresh) * CMP_W'(w_cur_den1);
    assign w_meets     = r_hvalid[r_cnt] && (r_hc[r_cnt] == r_nharm) && (w_lhs > w_rhs);
    // Cross-multiplied ratio compare; strict > keeps the lower index on ties.
    assign w_prod_new  = PROD_W'(w_cur_num) * PROD_W'(w_best_den1);
    assign w_prod_best = PROD_W'(r_best_num) * PROD_W'(w_cur_den1);
    assign w_take      = w_meets && (!r_best_found || (w_prod_new > w_prod_best));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_bin_idx    <= '0;
            r_nharm      <= '0;
            r_thresh     <= '0;
            r_cnt        <= '0;
            r_hvalid     <= '0;
            r_best_found <= 1'b0;
            r_best_idx   <= '0;
            r_best_num   <= '0;
            r_best_den   <= '0;
            r_out_found  <= 1'b0;
            r_out_idx    <= '0;
            r_out_num    <= '0;
            r_out_den    <= '0;
            r_hold_meets <= 1'b0;
            r_hold_idx   <= '0;
            r_hold_num   <= '0;
            r_hold_den   <= '0;
            for (int k = 0; k < NUM_HYP; k++) begin
                r_int[k]   <= '0;
                r_fracp[k] <= '0;
                r_frac[k]  <= '0;
                r_pos[k]   <= '0;
                r_hc[k]    <= '0;
                r_sk[k]    <= '0;
                r_num[k]   <= '0;
                r_den[k]   <= '0;
            end
        end else if (i_start) begin
            r_state      <= ST_ACCUM;
            r_bin_idx    <= '0;
            r_nharm      <= i_num_harmonics;
            r_thresh     <= i_corr_threshold;
            r_cnt        <= '0;
            r_best_found <= 1'b0;
            r_best_idx   <= '0;
            r_best_num   <= '0;
            r_best_den   <= '0;
            for (int k = 0; k < NUM_HYP; k++) begin
                r_int[k]    <= w_int_in[k];
                r_fracp[k]  <= w_frac_in[k];
                r_frac[k]   <= w_frac_in[k] + FRAC_HALF;
                r_pos[k]    <= POS_W'(w_int_in[k]) + POS_W'(w_frac_in[k][SFO_FRAC_WIDTH-1]);
                r_hvalid[k] <= (w_int_in[k] != '0);
                r_hc[k]     <= '0;
                r_sk[k]     <= SK_MAX;
                r_num[k]    <= '0;
                r_den[k]    <= '0;
            end
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_bin_idx <= r_bin_idx + FFT_LEN_LOG2'(1);
                        for (int k = 0; k < NUM_HYP; k++) begin
                            if (w_harm[k]) begin
                                r_num[k]  <= r_num[k] + ACC_W'(i_bin_mag);
                                r_hc[k]   <= r_hc[k] + MH_W'(1);
                                r_sk[k]   <= '0;
                                r_frac[k] <= w_frac_sum[k][SFO_FRAC_WIDTH-1:0];
                                r_pos[k]  <= r_pos[k] + POS_W'(r_int[k]) +
                                             POS_W'(w_frac_sum[k][SFO_FRAC_WIDTH]);
                            end else if (w_den_hit[k]) begin
                                r_den[k] <= r_den[k] + ACC_W'(i_bin_mag);
                            end else if (w_active[k] && (r_sk[k] < SK_MAX)) begin
                                r_sk[k] <= r_sk[k] + SK_W'(1);
                            end
                        end
                        if (w_frame_end) begin
                            r_state <= ST_REPORT;
                            r_cnt   <= '0;
                        end
                    end
                end
                ST_REPORT: begin
                    r_hold_idx   <= r_cnt;
                    r_hold_num   <= w_cur_num;
                    r_hold_den   <= w_cur_den;
                    r_hold_meets <= w_meets;
                    if (w_take) begin
                        r_best_found <= 1'b1;
                        r_best_idx   <= r_cnt;
                        r_best_num   <= w_cur_num;
                        r_best_den   <= w_cur_den;
                    end
                    if (r_cnt == HYP_W'(NUM_HYP - 1)) begin
                        r_state     <= ST_DONE;
                        r_out_found <= r_best_found | w_take;
                        r_out_idx   <= w_take ? r_cnt : r_best_idx;
                        r_out_num   <= w_take ? w_cur_num : r_best_num;
                        r_out_den   <= w_take ? w_cur_den : r_best_den;
                    end else begin
                        r_cnt <= r_cnt + HYP_W'(1);
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Live values while reporting, otherwise the last reported hypothesis.
    assign o_busy       = (r_state != ST_IDLE);
    assign o_hyp_valid  = w_report;
    assign o_hyp_index  = w_report ? r_cnt : r_hold_idx;
    assign o_hyp_num    = w_report ? w_cur_num : r_hold_num;
    assign o_hyp_den    = w_report ? w_cur_den : r_hold_den;
    assign o_hyp_meets  = w_report ? w_meets : r_hold_meets;
    assign o_best_valid = (r_state == ST_DONE);
    assign o_best_found = r_out_found;
    assign o_best_index = r_out_idx;
    assign o_best_num   = r_out_num;
    assign o_best_den   = r_out_den;

endmodule
